// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

  localparam int DEF_BITS       = 32;
  localparam int RESULT_REM_LSB = DEF_BITS;

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    FIXUP,
    SIGN,
    DONE
  } state_e;

endpackage : div_pkg

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the ALU issue logic and the divider sequencer.
interface div_seq_ctrl_if
  import div_pkg::*;
#(
  parameter int BITS = DEF_BITS
);

  logic                start;
  logic [BITS-1:0]     dividend;
  logic [BITS-1:0]     divisor;
  logic                busy;
  logic                done;
  logic                div_by_zero;
  logic [2*BITS-1:0]   result;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, result
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, result
  );

endinterface : div_seq_ctrl_if

// File: rtl/div_step.sv
// One non-restoring iteration; in fixup mode the same adder restores a negative remainder.
module div_step #(
  parameter int BITS = 32
) (
  input  logic [BITS:0]   i_a,
  input  logic [BITS-1:0] i_q,
  input  logic [BITS:0]   i_m,
  input  logic            i_fixup,
  output logic [BITS:0]   o_a,
  output logic [BITS-1:0] o_q
);

  logic [BITS:0] w_lhs;
  logic [BITS:0] w_rhs;
  logic          w_sub;
  logic [BITS:0] w_sum;

  // Subtraction is folded into the single adder as lhs + ~M + 1.
  assign w_sub = ~i_fixup & ~i_a[BITS];
  assign w_lhs = i_fixup ? i_a : {i_a[BITS-1:0], i_q[BITS-1]};
  assign w_rhs = i_m ^ {(BITS+1){w_sub}};
  assign w_sum = w_lhs + w_rhs + {{BITS{1'b0}}, w_sub};

  assign o_a = (i_fixup && !i_a[BITS]) ? i_a : w_sum;
  assign o_q = i_fixup ? i_q : {i_q[BITS-2:0], ~w_sum[BITS]};

endmodule : div_step

// File: rtl/div_seq_ctrl.sv
// Multi-cycle non-restoring divider sequencer: result = {remainder, quotient}.
// Define DIV_SIGNED_EN for two's-complement operands (adds a SIGN correction state).
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic           clk,
  input  logic           clear,
  div_seq_ctrl_if.slave  bus
);

  localparam int CW = $clog2(BITS);

  state_e            r_state;
  state_e            w_state_next;
  logic              w_busy;

  logic [BITS:0]     r_a;
  logic [BITS-1:0]   r_q;
  logic [BITS:0]     r_m;
  logic [CW-1:0]     r_count;
  logic              r_dbz_pend;
  logic              r_done;
  logic              r_dbz;
  logic [2*BITS-1:0] r_result;

  logic [BITS:0]     w_step_a;
  logic [BITS-1:0]   w_step_q;
  logic [BITS-1:0]   w_dvd_mag;
  logic [BITS-1:0]   w_dvs_mag;

`ifdef DIV_SIGNED_EN
  logic              r_neg_q;
  logic              r_neg_r;
  logic [BITS-1:0]   w_q_signed;
  logic [BITS-1:0]   w_r_signed;

  assign w_dvd_mag  = bus.dividend[BITS-1] ? ('0 - bus.dividend) : bus.dividend;
  assign w_dvs_mag  = bus.divisor[BITS-1]  ? ('0 - bus.divisor)  : bus.divisor;
  assign w_q_signed = r_neg_q ? ('0 - r_q) : r_q;
  assign w_r_signed = r_neg_r ? ('0 - r_a[BITS-1:0]) : r_a[BITS-1:0];
`else
  assign w_dvd_mag  = bus.dividend;
  assign w_dvs_mag  = bus.divisor;
`endif

  div_step #(.BITS(BITS)) u_step (
    .i_a     (r_a),
    .i_q     (r_q),
    .i_m     (r_m),
    .i_fixup (r_state == FIXUP),
    .o_a     (w_step_a),
    .o_q     (w_step_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_next = (bus.divisor == '0) ? DONE : ITER;
      end
      ITER: begin
        w_busy = 1'b1;
        if (r_count == '0) w_state_next = FIXUP;
      end
      FIXUP: begin
        w_busy = 1'b1;
`ifdef DIV_SIGNED_EN
        w_state_next = SIGN;
`else
        w_state_next = DONE;
`endif
      end
`ifdef DIV_SIGNED_EN
      SIGN: begin
        w_busy       = 1'b1;
        w_state_next = DONE;
      end
`endif
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_a        <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_count    <= '0;
      r_dbz_pend <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_result   <= '0;
`ifdef DIV_SIGNED_EN
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            // Divide by zero preloads the final image so DONE needs no special case.
            if (bus.divisor == '0) begin
              r_a        <= {1'b0, bus.dividend};
              r_q        <= '1;
              r_dbz_pend <= 1'b1;
            end else begin
              r_a        <= '0;
              r_q        <= w_dvd_mag;
              r_m        <= {1'b0, w_dvs_mag};
              r_count    <= CW'(BITS - 1);
              r_dbz_pend <= 1'b0;
`ifdef DIV_SIGNED_EN
              r_neg_q    <= bus.dividend[BITS-1] ^ bus.divisor[BITS-1];
              r_neg_r    <= bus.dividend[BITS-1];
`endif
            end
          end
        end
        ITER: begin
          r_a     <= w_step_a;
          r_q     <= w_step_q;
          r_count <= r_count - 1'b1;
        end
        FIXUP: r_a <= w_step_a;
`ifdef DIV_SIGNED_EN
        SIGN: begin
          r_q <= w_q_signed;
          r_a <= {1'b0, w_r_signed};
        end
`endif
        DONE: begin
          r_result <= {r_a[BITS-1:0], r_q};
          r_dbz    <= r_dbz_pend;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.result      = r_result;

endmodule : div_seq_ctrl

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl (BITS=32); vectors switch with DIV_SIGNED_EN.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int BITS = 32;
`ifdef DIV_SIGNED_EN
  localparam int LAT = BITS + 3;
`else
  localparam int LAT = BITS + 2;
`endif
  localparam int BOUND = 200;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  logic clk = 1'b0;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  div_seq_ctrl_if #(.BITS(BITS)) bus ();

  div_seq_ctrl #(.BITS(BITS)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that raised done.
  task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs,
                        output int lat, output logic busy_seen);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 32'hA5A5_A5A5;
    bus.divisor  = 32'h0000_0003;
    lat       = 0;
    busy_seen = 1'b0;
    while (!bus.done && lat < BOUND) begin
      busy_seen |= bus.busy;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vecs[12];
  int   nvec;

  initial begin
    int   lat;
    logic busy_seen;
    int   pulses;

`ifdef DIV_SIGNED_EN
    vecs[0]  = '{32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0};
    vecs[2]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{32'h0000_002A, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_002A, 1'b1};
    vecs[5]  = '{32'hFFFF_FFD6, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b1};
    vecs[6]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[7]  = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[8]  = '{32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
    vecs[9]  = '{32'd123456789, 32'hFFFF_D8F0, 32'hFFFF_CFC7, 32'd6789,      1'b0};
    vecs[10] = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'd0,         1'b0};
    vecs[11] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
    nvec = 12;
`else
    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
    vecs[2]  = '{32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
    vecs[3]  = '{32'd42,        32'd0,         32'hFFFF_FFFF, 32'd42,        1'b1};
    vecs[4]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
    vecs[5]  = '{32'd7,         32'd7,         32'd1,         32'd0,         1'b0};
    vecs[6]  = '{32'h8000_0000, 32'd2,         32'h4000_0000, 32'd0,         1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    vecs[8]  = '{32'd123456789, 32'd10000,     32'd12345,     32'd6789,      1'b0};
    vecs[9]  = '{32'd1,         32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};
    vecs[10] = '{32'hDEAD_BEEF, 32'h10,        32'h0DEA_DBEE, 32'hF,         1'b0};
    vecs[11] = '{32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1};
    nvec = 12;
`endif

    clear        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   {63'd0, bus.busy},        64'd0);
    check("reset done",   {63'd0, bus.done},        64'd0);
    check("reset dbz",    {63'd0, bus.div_by_zero}, 64'd0);
    check("reset result", bus.result,               64'd0);
    clear = 1'b1;
    @(posedge clk); #1;

    // Back-to-back table: each op issues in the done cycle of the previous one.
    for (int i = 0; i < nvec; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat, busy_seen);
      check($sformatf("v%0d latency", i), 64'(lat), vecs[i].dbz ? 64'd1 : 64'(LAT));
      check($sformatf("v%0d quotient", i), {32'd0, bus.result[RESULT_REM_LSB-1:0]}, {32'd0, vecs[i].q});
      check($sformatf("v%0d remainder", i), {32'd0, bus.result[2*BITS-1:RESULT_REM_LSB]}, {32'd0, vecs[i].r});
      check($sformatf("v%0d dbz", i), {63'd0, bus.div_by_zero}, {63'd0, vecs[i].dbz});
      check($sformatf("v%0d busy seen", i), {63'd0, busy_seen}, {63'd0, ~vecs[i].dbz});
    end
    @(posedge clk); #1;
    check("done one-cycle pulse", {63'd0, bus.done}, 64'd0);
    check("dbz held after done", {63'd0, bus.div_by_zero}, {63'd0, vecs[nvec-1].dbz});

    // Start re-pulsed at ITER cycle 10 must be ignored and never queued.
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < BOUND) begin
      if (lat == 10) begin
        bus.start = 1'b1; bus.dividend = 32'd55; bus.divisor = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("restart latency", 64'(lat), 64'(LAT));
    check("restart result", bus.result, {32'd2, 32'd14});
    pulses = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) pulses++;
    end
    check("restart not queued", 64'(pulses), 64'd0);

    // Asynchronous clear at ITER cycle 17.
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (17) @(posedge clk);
    #3;
    clear = 1'b0;
    #1;
    check("clear busy",   {63'd0, bus.busy},        64'd0);
    check("clear done",   {63'd0, bus.done},        64'd0);
    check("clear dbz",    {63'd0, bus.div_by_zero}, 64'd0);
    check("clear result", bus.result,               64'd0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    check("post-clear idle", {63'd0, bus.busy}, 64'd0);
    run_op(32'd1000, 32'd3, lat, busy_seen);
    check("post-clear latency", 64'(lat), 64'(LAT));
    check("post-clear result", bus.result, {32'd1, 32'd333});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_seq_ctrl

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for the non-restoring integer divider used by the ALU's DIV operation. It captures operands on a start strobe and runs one shift/add-or-subtract step per clock under a small FSM. It then applies the final remainder restore and returns a packed {remainder, quotient} word for the HI/LO registers. It replaces the single-cycle unrolled divider on the bus datapath, so DIV costs BITS+2 cycles but holds only one step's worth of adder logic.

## Interface
- BITS, 32, operand width; must be ≥ 2
- clk  in  1  system clock, rising edge
- clear  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- dividend  in  BITS  numerator, sampled with start
- divisor  in  BITS  denominator, sampled with start
- busy  out  1  high from the cycle after an accepted start through FIXUP (or SIGN)
- done  out  1  one-cycle pulse; result is valid from this cycle onward
- div_by_zero  out  1  valid with done; held until the next accepted start
- result  out  2*BITS  [2*BITS-1:BITS] = remainder, [BITS-1:0] = quotient; held until the next accepted start

## Operation
- Reset (clear=0, at any time, including mid-operation):
  - FSM forced to IDLE.
  - busy, done, div_by_zero and result all 0.
  - Internal A (BITS+1 bits), Q, M and the step counter are cleared.
- FSM states and transitions:
  - IDLE: start=1 loads A=0, Q=dividend, M={1'b0,divisor} and count=BITS-1, then goes to ITER. If divisor==0, it goes to DONE instead.
  - ITER: performs one step per cycle.
    - {A,Q} shifts left by 1.
    - If the old A sign bit is 1, A=A+M; otherwise A=A−M.
    - Q[0] = ~A_new[BITS].
    - count decrements; at count==0 the FSM goes to FIXUP.
  - FIXUP: if A[BITS]==1, A=A+M. Goes to DONE (or to SIGN when DIV_SIGNED_EN is defined).
  - DONE: result={A[BITS-1:0],Q}, done=1, busy=0. Goes to IDLE.
- Divide by zero:
  - div_by_zero=1.
  - Quotient = {BITS{1'b1}}, remainder = dividend (unsigned view).
  - No ITER cycles are spent.
- start while busy, or while in DONE, is ignored and not queued.
- Arithmetic on A is BITS+1 bits wide and wraps modulo 2^(BITS+1). The overflow bit is never observable.

## Timing
- Start is accepted at edge N; ITER occupies edges N+1 through N+BITS.
- FIXUP happens at N+BITS+1; done is high in the cycle after edge N+BITS+2. Latency is BITS+2 cycles (34 for BITS=32).
- Divide-by-zero: done is high after edge N+1 (1 cycle latency). busy never rises.
- Back-to-back operation: start may be asserted in the cycle after done (IDLE). Minimum issue interval is BITS+3 cycles.
- result and div_by_zero change only at the edge that raises done (and are cleared by reset).

## Configuration
- DIV_SIGNED_EN defined:
  - Operands are two's complement. At load, |dividend| and |divisor| are used, and both operand signs are registered.
  - A SIGN state after FIXUP negates the quotient if the signs differ, and negates the remainder if the dividend is negative.
  - Latency becomes BITS+3.
  - Divide-by-zero output is unchanged (quotient all ones, remainder = raw dividend).
  - The most-negative dividend magnitude is treated as an unsigned 2^(BITS-1).
- Undefined: operands are unsigned, the SIGN state does not exist, and latency is BITS+2.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, ITER, FIXUP, SIGN, DONE);
  - the default BITS;
  - the RESULT_REM_LSB = BITS field constant.
- Sub-module div_step: purely combinational, one non-restoring iteration. It takes (A, Q, M) and returns (A', Q'). Its add/sub is the only BITS+1-bit adder in the block.

## Test plan
- Unsigned, BITS=32: 100 ÷ 7 → done 34 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- 0xFFFFFFFF ÷ 1 → quotient=0xFFFFFFFF, remainder=0. Then 5 ÷ 9 → quotient=0, remainder=5 (exercises FIXUP restore).
- 42 ÷ 0 → done one cycle after start; div_by_zero=1, quotient=0xFFFFFFFF, remainder=42, busy stays 0.
- Start pulsed again at ITER cycle 10 with new operands → ignored; the original result is returned and the new operands are never seen.
- clear dropped at ITER cycle 17 → all outputs 0 immediately. A fresh start after release yields a correct 1000 ÷ 3 = 333 r 1.
- DIV_SIGNED_EN defined: −7 ÷ 2 → quotient=−3, remainder=−1, latency 35. 7 ÷ −2 → quotient=−3, remainder=1.
